pattern_playback_sequencer: RTL and testbench

- Sequences the on-LED playback of a stored game pattern, one 3-bit symbol at a time.
- Each symbol is shown as a one-hot LED for ON_CYCLES, followed by a blank gap of OFF_CYCLES.
- Sits between the pattern shift register and the LED output mux; started by the active mode FSM after pattern generation.
- Reports done so the FSM can enable the input handler.

---
 rtl/pattern_playback_sequencer.sv | 168 ++++++++++++++++
 tb/tb_pattern_playback_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_playback_sequencer.sv
// Plays a stored pattern of 3-bit symbols as one-hot LEDs,
// ON_CYCLES lit then OFF_CYCLES blank, and pulses done at the end.
module pattern_playback_sequencer #(
  parameter int MAX_LEN    = 25,
  parameter int ON_CYCLES  = 500,
  parameter int OFF_CYCLES = 250,
  parameter int IDX_W      = 5
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic [IDX_W-1:0]       length_i,
  input  logic                   reverse_i,
  input  logic [3*MAX_LEN-1:0]   pattern_i,
  input  logic                   abort_i,
  output logic [7:0]             led_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [IDX_W-1:0]       index_o
);

  localparam int TMAX =
    (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] ON_LAST =
    TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST =
    (OFF_CYCLES > 0) ? TW'(OFF_CYCLES - 1) : '0;
  localparam logic [IDX_W-1:0] MAX_IDX =
    IDX_W'(MAX_LEN);
  localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GAP,
    FINISH
  } state_t;

  state_t               state_q, state_d;
  logic [3*MAX_LEN-1:0] snap_q, snap_d;
  logic                 rev_q, rev_d;
  logic [IDX_W-1:0]     len_q, len_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [TW-1:0]        tmr_q, tmr_d;
  logic [7:0]           led_q, led_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [IDX_W-1:0]     index_q, index_d;

  logic [IDX_W-1:0]     eff_len;
  logic [IDX_W-1:0]     pos;
  logic [2:0]           cur_sym;
  logic                 advance;

  assign eff_len =
    (length_i > MAX_IDX) ? MAX_IDX : length_i;
  assign pos =
    rev_q ? (len_q - ONE - idx_q) : idx_q;
  assign cur_sym = snap_q[3*pos +: 3];

  // Outputs are a registered view of the state
  // the FSM held during the previous cycle.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    rev_d   = rev_q;
    len_d   = len_q;
    idx_d   = idx_q;
    tmr_d   = tmr_q;
    advance = 1'b0;
    led_d   = '0;
    busy_d  = (state_q != IDLE);
    done_d  = (state_q == FINISH);
    index_d = idx_q;
    if (state_q == SHOW) begin
      led_d = 8'd1 << cur_sym;
    end
    unique case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          snap_d  = pattern_i;
          rev_d   = reverse_i;
          len_d   = eff_len;
          idx_d   = '0;
          tmr_d   = '0;
          state_d = (eff_len == '0) ? FINISH : SHOW;
        end
      end
      SHOW: begin
        if (tmr_q == ON_LAST) begin
          tmr_d = '0;
          if (OFF_CYCLES > 0) begin
            state_d = GAP;
          end else begin
            advance = 1'b1;
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      GAP: begin
        if (tmr_q == OFF_LAST) begin
          tmr_d   = '0;
          advance = 1'b1;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      FINISH: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (advance) begin
      if (idx_q == len_q - ONE) begin
        state_d = FINISH;
      end else begin
        idx_d   = idx_q + ONE;
        state_d = SHOW;
      end
    end
    if (abort_i && state_q != IDLE) begin
      state_d = IDLE;
      idx_d   = '0;
      tmr_d   = '0;
      led_d   = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      index_d = '0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      snap_q  <= '0;
      rev_q   <= 1'b0;
      len_q   <= '0;
      idx_q   <= '0;
      tmr_q   <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      rev_q   <= rev_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      index_q <= index_d;
    end
  end

  assign led_o   = led_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign index_o = index_q;

endmodule

// File: tb/tb_pattern_playback_sequencer.sv
// Bench for pattern_playback_sequencer: two instances
// (with and without a blank gap) driven from a vector table.
module tb_pattern_playback_sequencer;

  localparam int ML   = 25;
  localparam int IW   = 5;
  localparam int ONA  = 4;
  localparam int OFFA = 2;
  localparam int ONB  = 3;
  localparam int OFFB = 0;

  typedef struct {
    bit              b;
    logic [IW-1:0]   len;
    bit              rev;
    logic [3*ML-1:0] pat;
    int              mid_k;
    int              abort_k;
    int              exp_done_k;
    int              exp_syms;
  } vec_t;

  typedef struct packed {
    logic [7:0]    led;
    logic          busy;
    logic          done;
    logic [IW-1:0] idx;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_a, start_b;
  logic [IW-1:0]   length;
  logic            reverse;
  logic [3*ML-1:0] pattern;
  logic            abort;
  logic [7:0]      led_a, led_b;
  logic            busy_a, busy_b;
  logic            done_a, done_b;
  logic [IW-1:0]   idx_a, idx_b;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pattern_playback_sequencer #(
    .MAX_LEN(ML), .ON_CYCLES(ONA),
    .OFF_CYCLES(OFFA), .IDX_W(IW)
  ) u_a (
    .clock_i(clk), .reset_i(rst),
    .start_i(start_a), .length_i(length),
    .reverse_i(reverse), .pattern_i(pattern),
    .abort_i(abort), .led_o(led_a),
    .busy_o(busy_a), .done_o(done_a),
    .index_o(idx_a)
  );

  pattern_playback_sequencer #(
    .MAX_LEN(ML), .ON_CYCLES(ONB),
    .OFF_CYCLES(OFFB), .IDX_W(IW)
  ) u_b (
    .clock_i(clk), .reset_i(rst),
    .start_i(start_b), .length_i(length),
    .reverse_i(reverse), .pattern_i(pattern),
    .abort_i(abort), .led_o(led_b),
    .busy_o(busy_b), .done_o(done_b),
    .index_o(idx_b)
  );

  function automatic exp_t obs(input bit b);
    exp_t o;
    if (b) o = {led_b, busy_b, done_b, idx_b};
    else   o = {led_a, busy_a, done_a, idx_a};
    return o;
  endfunction

  task automatic chk(input string nm,
                     input exp_t got,
                     input exp_t exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got led=%h busy=%b done=%b idx=%0d, want led=%h busy=%b done=%b idx=%0d",
               nm, got.led, got.busy, got.done, got.idx,
               exp.led, exp.busy, exp.done, exp.idx);
    end
  endtask

  task automatic chk_int(input string nm,
                         input int got,
                         input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d",
               nm, got, exp);
    end
  endtask

  task automatic play(input string tag,
                      input vec_t v);
    exp_t q[$];
    exp_t e;
    int eff, p, on, last, j, r, pos;
    int k, ndone, done_k, maxidx;
    logic [2:0] sym;
    eff  = (int'(v.len) > ML) ? ML : int'(v.len);
    on   = v.b ? ONB : ONA;
    p    = v.b ? (ONB + OFFB) : (ONA + OFFA);
    last = (v.abort_k >= 0) ? v.abort_k + 12
                            : eff * p + 2;
    for (int kk = 0; kk <= last; kk++) begin
      e = '0;
      if (kk >= 1 && kk <= eff * p) begin
        j   = (kk - 1) / p;
        r   = (kk - 1) % p;
        pos = v.rev ? (eff - 1 - j) : j;
        sym = v.pat[3*pos +: 3];
        if (r < on) e.led = 8'd1 << sym;
        e.busy = 1'b1;
        e.idx  = IW'(j);
      end else if (kk == eff * p + 1) begin
        e.busy = 1'b1;
        e.done = 1'b1;
        e.idx  = (eff > 0) ? IW'(eff - 1) : '0;
      end
      if (v.abort_k >= 0 && kk > v.abort_k) e = '0;
      q.push_back(e);
    end
    length  = v.len;
    reverse = v.rev;
    pattern = v.pat;
    if (v.b) start_b = 1'b1;
    else     start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    k = 0; ndone = 0; done_k = -1; maxidx = -1;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk($sformatf("%s k=%0d", tag, k), obs(v.b), e);
      if (obs(v.b).done === 1'b1) begin
        ndone++;
        if (done_k < 0) done_k = k;
      end
      if (obs(v.b).led !== 8'h00 &&
          int'(obs(v.b).idx) > maxidx)
        maxidx = int'(obs(v.b).idx);
      start_a = 1'b0;
      start_b = 1'b0;
      abort   = 1'b0;
      if (k == v.mid_k) begin
        if (v.b) start_b = 1'b1;
        else     start_a = 1'b1;
        pattern = ~v.pat;
        length  = 5'd7;
        reverse = ~v.rev;
      end else if (k == v.abort_k) begin
        abort = 1'b1;
      end
      @(negedge clk);
      k++;
    end
    start_a = 1'b0;
    start_b = 1'b0;
    abort   = 1'b0;
    chk_int({tag, " done_cycle"}, done_k, v.exp_done_k);
    chk_int({tag, " done_count"}, ndone,
            (v.exp_done_k >= 0) ? 1 : 0);
    chk_int({tag, " symbols"}, maxidx + 1, v.exp_syms);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[7];
    logic [3*ML-1:0] base, rnd1, rnd2;
    base = 75'h1C5;
    rnd1 = {$urandom, $urandom, $urandom};
    rnd2 = {$urandom, $urandom, $urandom};
    tbl[0] = '{0, 5'd3,  0, base, -1, -1,  19,  3};
    tbl[1] = '{0, 5'd3,  1, base, -1, -1,  19,  3};
    tbl[2] = '{0, 5'd0,  0, base, -1, -1,   1,  0};
    tbl[3] = '{0, 5'd31, 0, rnd1, -1, -1, 151, 25};
    tbl[4] = '{1, 5'd3,  0, base, -1, -1,  10,  3};
    tbl[5] = '{0, 5'd4,  0, rnd2,  8, -1,  25,  4};
    tbl[6] = '{0, 5'd3,  0, base, -1,  7,  -1,  2};

    rst = 1'b1;
    start_a = 1'b1;
    start_b = 1'b1;
    length  = 5'd3;
    reverse = 1'b0;
    pattern = base;
    abort   = 1'b0;
    @(negedge clk);
    chk("reset1 a", obs(0), '0);
    chk("reset1 b", obs(1), '0);
    @(negedge clk);
    chk("reset2 a", obs(0), '0);
    chk("reset2 b", obs(1), '0);
    rst = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    @(negedge clk);
    chk("post_reset a", obs(0), '0);
    chk("post_reset b", obs(1), '0);

    for (int i = 0; i < 7; i++) begin
      play($sformatf("vec%0d", i), tbl[i]);
    end
    play("restart", tbl[0]);
    play("restart_rev", tbl[1]);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
